// File: rtl/lcd_bus_rx_if.sv
// 8080-style LCD write bus as seen between the LCD controller (master)
// and the receiving display model (slave).
interface lcd_bus_rx_if;
    logic [7:0] lcd_db;
    logic       lcd_wr;
    logic       lcd_d_c;
    logic       lcd_rd;
    logic       lcd_reset;

    modport master (
        output lcd_db,
        output lcd_wr,
        output lcd_d_c,
        output lcd_rd,
        output lcd_reset
    );

    modport slave (
        input lcd_db,
        input lcd_wr,
        input lcd_d_c,
        input lcd_rd,
        input lcd_reset
    );
endinterface

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: receiving end of the 8-bit 8080 LCD write bus.
// Decodes CASET/PASET window commands and RAMWR RGB565 pixel streams
// (high byte first) into per-pixel writes carrying x/y coordinates.
// Optional build macro LCD_BUS_RX_ERR_EN enables the sticky rx_err flag;
// without it rx_err is tied low and everything else is identical.
module lcd_bus_rx #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk_100,
    input  logic        resetN,
    lcd_bus_rx_if.slave bus,
    output logic        pix_valid,
    output logic [31:0] pix_x,
    output logic [31:0] pix_y,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame,
    output logic        rx_err
);
    localparam logic [15:0] H_LAST = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST = 16'(V_RES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    // synchronisers
    logic       wr_s1_r, wr_s2_r, wr_s3_r;
    logic       dc_s1_r, dc_s2_r;
    logic [7:0] db_s1_r, db_s2_r;
    logic       prst_s1_r, prst_s2_r;

    // registered byte event
    logic       evt_r;
    logic       evt_dc_r;
    logic [7:0] evt_db_r;

    // protocol state
    state_t      state_r;
    logic [1:0]  arg_cnt_r;
    logic [7:0]  s_hi_r, s_lo_r, e_hi_r;
    logic [15:0] sc_r, ec_r, sp_r, ep_r;
    logic [15:0] cur_x_r, cur_y_r;
    logic        phase_r;
    logic [6:0]  hi_r;   // {R[4:1], G[5:3]} of the pending high byte

    logic        hold_s;
    logic        cmd_s;
    logic        data_s;
    logic [15:0] new_s_s;
    logic [15:0] new_e_s;
    logic [15:0] lim_s;
    logic        win_ok_s;

    assign hold_s = ~prst_s2_r;

    // Two-flop synchronisers for the bus plus a history flop on the strobe
    always_ff @(posedge clk_100) begin
        if (!resetN) begin
            wr_s1_r   <= 1'b1;
            wr_s2_r   <= 1'b1;
            wr_s3_r   <= 1'b1;
            dc_s1_r   <= 1'b0;
            dc_s2_r   <= 1'b0;
            db_s1_r   <= 8'h00;
            db_s2_r   <= 8'h00;
            prst_s1_r <= 1'b1;
            prst_s2_r <= 1'b1;
        end else begin
            wr_s1_r   <= bus.lcd_wr;
            wr_s2_r   <= wr_s1_r;
            wr_s3_r   <= wr_s2_r;
            dc_s1_r   <= bus.lcd_d_c;
            dc_s2_r   <= dc_s1_r;
            db_s1_r   <= bus.lcd_db;
            db_s2_r   <= db_s1_r;
            prst_s1_r <= bus.lcd_reset;
            prst_s2_r <= prst_s1_r;
        end
    end

    // Capture one byte per synchronised wr rising edge
    always_ff @(posedge clk_100) begin
        if (!resetN || hold_s) begin
            evt_r    <= 1'b0;
            evt_dc_r <= 1'b0;
            evt_db_r <= 8'h00;
        end else begin
            evt_r    <= wr_s2_r & ~wr_s3_r;
            evt_dc_r <= dc_s2_r;
            evt_db_r <= db_s2_r;
        end
    end

    // Classify the captured byte and judge a candidate window on its last byte
    always_comb begin
        cmd_s   = evt_r & ~evt_dc_r;
        data_s  = evt_r & evt_dc_r;
        new_s_s = {s_hi_r, s_lo_r};
        new_e_s = {e_hi_r, evt_db_r};
        if (state_r == ST_PASET) begin
            lim_s = V_LAST;
        end else begin
            lim_s = H_LAST;
        end
        win_ok_s = (new_s_s <= new_e_s) && (new_e_s <= lim_s);
    end

    // Command FSM, window registers, pixel cursor and registered pixel outputs
    always_ff @(posedge clk_100) begin
        if (!resetN || hold_s) begin
            state_r   <= ST_IDLE;
            arg_cnt_r <= 2'd0;
            s_hi_r    <= 8'h00;
            s_lo_r    <= 8'h00;
            e_hi_r    <= 8'h00;
            sc_r      <= 16'd0;
            ec_r      <= H_LAST;
            sp_r      <= 16'd0;
            ep_r      <= V_LAST;
            cur_x_r   <= 16'd0;
            cur_y_r   <= 16'd0;
            phase_r   <= 1'b0;
            hi_r      <= 7'd0;
            pix_valid <= 1'b0;
            pix_x     <= 32'd0;
            pix_y     <= 32'd0;
            red       <= 4'd0;
            green     <= 4'd0;
            blue      <= 4'd0;
            frame     <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            frame     <= 1'b0;
            if (cmd_s) begin
                // any command aborts whatever was in progress
                arg_cnt_r <= 2'd0;
                phase_r   <= 1'b0;
                case (evt_db_r)
                    8'h2A: state_r <= ST_CASET;
                    8'h2B: state_r <= ST_PASET;
                    8'h2C: begin
                        state_r <= ST_RAMWR;
                        cur_x_r <= sc_r;
                        cur_y_r <= sp_r;
                    end
                    8'h01: begin
                        state_r <= ST_IDLE;
                        sc_r    <= 16'd0;
                        ec_r    <= H_LAST;
                        sp_r    <= 16'd0;
                        ep_r    <= V_LAST;
                        cur_x_r <= 16'd0;
                        cur_y_r <= 16'd0;
                    end
                    default: state_r <= ST_SKIP;
                endcase
            end else if (data_s) begin
                case (state_r)
                    ST_CASET, ST_PASET: begin
                        arg_cnt_r <= arg_cnt_r + 2'd1;
                        case (arg_cnt_r)
                            2'd0: s_hi_r <= evt_db_r;
                            2'd1: s_lo_r <= evt_db_r;
                            2'd2: e_hi_r <= evt_db_r;
                            default: begin
                                // window commits only once all four bytes are in
                                if (win_ok_s) begin
                                    if (state_r == ST_CASET) begin
                                        sc_r <= new_s_s;
                                        ec_r <= new_e_s;
                                    end else begin
                                        sp_r <= new_s_s;
                                        ep_r <= new_e_s;
                                    end
                                end else begin
                                    sc_r <= sc_r;
                                end
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        phase_r <= ~phase_r;
                        if (!phase_r) begin
                            hi_r <= {evt_db_r[7:4], evt_db_r[2:0]};
                        end else begin
                            pix_valid <= 1'b1;
                            pix_x     <= {16'd0, cur_x_r};
                            pix_y     <= {16'd0, cur_y_r};
                            red       <= hi_r[6:3];
                            green     <= {hi_r[2:0], evt_db_r[7]};
                            blue      <= evt_db_r[4:1];
                            frame     <= (cur_x_r == ec_r) && (cur_y_r == ep_r);
                            if (cur_x_r == ec_r) begin
                                cur_x_r <= sc_r;
                                if (cur_y_r == ep_r) begin
                                    cur_y_r <= sp_r;
                                end else begin
                                    cur_y_r <= cur_y_r + 16'd1;
                                end
                            end else begin
                                cur_x_r <= cur_x_r + 16'd1;
                            end
                        end
                    end
                    default: state_r <= state_r;   // IDLE/SKIP drop data
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

`ifdef LCD_BUS_RX_ERR_EN
    logic rd_s1_r, rd_s2_r;
    logic known_cmd_s;
    logic err_s;

    // Synchronise the read strobe for overlap detection
    always_ff @(posedge clk_100) begin
        if (!resetN) begin
            rd_s1_r <= 1'b1;
            rd_s2_r <= 1'b1;
        end else begin
            rd_s1_r <= bus.lcd_rd;
            rd_s2_r <= rd_s1_r;
        end
    end

    // Collect every error condition into one set pulse
    always_comb begin
        case (evt_db_r)
            8'h2A, 8'h2B, 8'h2C, 8'h01: known_cmd_s = 1'b1;
            default:                    known_cmd_s = 1'b0;
        endcase
        err_s = 1'b0;
        if (cmd_s && !known_cmd_s) begin
            err_s = 1'b1;
        end else if (data_s && (state_r == ST_IDLE)) begin
            err_s = 1'b1;
        end else if (data_s && ((state_r == ST_CASET) || (state_r == ST_PASET)) &&
                     (arg_cnt_r == 2'd3) && !win_ok_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
        if (!rd_s2_r && !wr_s2_r) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // Sticky error flag; only resetN clears it, panel reset leaves it alone
    always_ff @(posedge clk_100) begin
        if (!resetN) begin
            rx_err <= 1'b0;
        end else if (err_s) begin
            rx_err <= 1'b1;
        end else begin
            rx_err <= rx_err;
        end
    end
`else
    assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: directed table of pixels, hand-written
// corner sequences and a random byte stream checked against a reference
// model that derives pixel coordinates from the pixel index in the window.
`timescale 1ns/1ps
module tb_lcd_bus_rx;
    logic        clk_100 = 1'b0;
    logic        resetN;
    logic        pix_valid;
    logic [31:0] pix_x, pix_y;
    logic [3:0]  red, green, blue;
    logic        frame, rx_err;

    lcd_bus_rx_if bus ();

    lcd_bus_rx #(.H_RES(320), .V_RES(240)) dut (
        .clk_100  (clk_100),
        .resetN   (resetN),
        .bus      (bus),
        .pix_valid(pix_valid),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .frame    (frame),
        .rx_err   (rx_err)
    );

    always #5 clk_100 = ~clk_100;

`ifdef LCD_BUS_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int         x;
        int         y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        bit         f;
    } pix_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         x;
        int         y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        bit         f;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    pix_t exp_q[$];
    pix_t mon_p;

    // reference model state
    int         m_sc, m_ec, m_sp, m_ep;
    int         m_cmd;      // active command byte, -1 when idle
    int         m_npix;     // pixels completed since RAMWR
    bit         m_hi_pend;
    logic [7:0] m_hi;
    int         m_args[$];
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic pix_t mk_pix(input logic [15:0] px, input int k, input int sc, input int sp,
                                    input int w, input int h);
        pix_t       p;
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        int         kk;
        r5 = px[15:11];
        g6 = px[10:5];
        b5 = px[4:0];
        kk = k % (w * h);
        p.x = sc + kk % w;
        p.y = sp + kk / w;
        p.f = (kk == w * h - 1);
        p.r = r5[4:1];
        p.g = g6[5:2];
        p.b = b5[4:1];
        return p;
    endfunction

    task automatic model_defaults();
        m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
        m_cmd = -1; m_npix = 0; m_hi_pend = 1'b0;
        m_args.delete();
    endtask

    task automatic model_byte(input bit dc, input logic [7:0] b);
        int s, e, lim;
        if (!dc) begin
            m_args.delete();
            m_hi_pend = 1'b0;
            m_npix = 0;
            case (b)
                8'h2A, 8'h2B, 8'h2C: m_cmd = int'(b);
                8'h01: model_defaults();
                default: begin
                    m_cmd = int'(b);
                    m_err = 1'b1;
                end
            endcase
        end else if (m_cmd == 32'h2A || m_cmd == 32'h2B) begin
            m_args.push_back(int'(b));
            if (m_args.size() == 4) begin
                s = m_args[0] * 256 + m_args[1];
                e = m_args[2] * 256 + m_args[3];
                lim = (m_cmd == 32'h2A) ? 320 : 240;
                if (s <= e && e < lim) begin
                    if (m_cmd == 32'h2A) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else begin
                    m_err = 1'b1;
                end
                m_cmd = -1;
                m_args.delete();
            end
        end else if (m_cmd == 32'h2C) begin
            if (!m_hi_pend) begin
                m_hi = b;
                m_hi_pend = 1'b1;
            end else begin
                exp_q.push_back(mk_pix({m_hi, b}, m_npix, m_sc, m_sp,
                                       m_ec - m_sc + 1, m_ep - m_sp + 1));
                m_npix++;
                m_hi_pend = 1'b0;
            end
        end else if (m_cmd == -1) begin
            m_err = 1'b1;
        end
    endtask

    // Every pixel pulse is matched against the model's expected queue
    always @(negedge clk_100) begin
        if (pix_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pix: got pulse at (%0d,%0d), expected no pulse", pix_x, pix_y);
            end else begin
                mon_p = exp_q.pop_front();
                chk("mon_x", pix_x, mon_p.x);
                chk("mon_y", pix_y, mon_p.y);
                chk("mon_rgb", {20'd0, red, green, blue}, {20'd0, mon_p.r, mon_p.g, mon_p.b});
                chk("mon_frame", {31'd0, frame}, {31'd0, mon_p.f});
            end
        end else if (frame) begin
            chk("frame_without_pix", {31'd0, frame}, 32'd0);
        end
    end

    task automatic send_byte(input bit dc, input logic [7:0] b);
        @(posedge clk_100); #1;
        bus.lcd_db  = b;
        bus.lcd_d_c = dc;
        bus.lcd_wr  = 1'b0;
        model_byte(dc, b);
        repeat (3) @(posedge clk_100);
        #1 bus.lcd_wr = 1'b1;
        repeat (3) @(posedge clk_100);
    endtask

    task automatic wait_pix(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100);
            if (pix_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    task automatic do_reset();
        resetN        = 1'b0;
        bus.lcd_wr    = 1'b1;
        bus.lcd_rd    = 1'b1;
        bus.lcd_reset = 1'b1;
        bus.lcd_d_c   = 1'b0;
        bus.lcd_db    = 8'h00;
        repeat (3) @(posedge clk_100);
        #1 resetN = 1'b1;
        model_defaults();
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_win(input logic [7:0] cmd, input int lim);
        int s, e, t, n;
        s = $urandom_range(0, lim - 1);
        e = s + $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) begin t = s; s = e; e = t; end
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
        send_byte(1'b0, cmd);
        if (n > 0) send_byte(1'b1, 8'(s >> 8));
        if (n > 1) send_byte(1'b1, 8'(s));
        if (n > 2) send_byte(1'b1, 8'(e >> 8));
        if (n > 3) send_byte(1'b1, 8'(e));
    endtask

    initial begin
        vec_t tbl[7];
        int   lat;
        int   p0;
        tbl[0] = '{8'hF8, 8'h00, 10, 5, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[1] = '{8'h07, 8'hE0, 11, 5, 4'h0, 4'hF, 4'h0, 1'b0};
        tbl[2] = '{8'h00, 8'h1F, 12, 5, 4'h0, 4'h0, 4'hF, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 10, 6, 4'hF, 4'hF, 4'hF, 1'b0};
        tbl[4] = '{8'h84, 8'h10, 11, 6, 4'h8, 4'h8, 4'h8, 1'b0};
        tbl[5] = '{8'h12, 8'h34, 12, 6, 4'h1, 4'h4, 4'hA, 1'b1};
        tbl[6] = '{8'hAB, 8'hCD, 10, 5, 4'hA, 4'h7, 4'h6, 1'b0};

        do_reset();
        @(negedge clk_100);
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_pix_x", pix_x, 32'd0);
        chk("rst_pix_y", pix_y, 32'd0);
        chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);

        // first pixel at the default origin, with latency measured from the wr rise
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8);
        @(posedge clk_100); #1;
        bus.lcd_db = 8'h00; bus.lcd_d_c = 1'b1; bus.lcd_wr = 1'b0;
        model_byte(1'b1, 8'h00);
        repeat (3) @(posedge clk_100);
        #1 bus.lcd_wr = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_100); #1;
            if (pix_valid) begin lat = i; break; end
        end
        chk("first_latency", lat, 32'd4);
        chk("first_xy", {pix_x[15:0], pix_y[15:0]}, 32'd0);
        chk("first_rgb", {20'd0, red, green, blue}, 32'h0000_0F00);

        // windowed stream with wrap and frame pulse
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd10); send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd12);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd5); send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd6);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 7; i++) begin
            send_byte(1'b1, tbl[i].hi);
            send_byte(1'b1, tbl[i].lo);
            wait_pix("tbl_pulse");
            chk("tbl_x", pix_x, tbl[i].x);
            chk("tbl_y", pix_y, tbl[i].y);
            chk("tbl_rgb", {20'd0, red, green, blue}, {20'd0, tbl[i].r, tbl[i].g, tbl[i].b});
            chk("tbl_frame", {31'd0, frame}, {31'd0, tbl[i].f});
        end

        // truncated CASET leaves the window alone
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h30);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        wait_pix("trunc_pulse");
        chk("trunc_xy", {pix_x[15:0], pix_y[15:0]}, {16'd10, 16'd5});

        // command between hi and lo drops the hi byte
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h07);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hE0); send_byte(1'b1, 8'h1F);
        wait_pix("abort_pulse");
        chk("abort_xy", {pix_x[15:0], pix_y[15:0]}, {16'd10, 16'd5});
        chk("abort_rgb", {20'd0, red, green, blue}, 32'h0000_0E0F);
        chk("err_clean", {31'd0, rx_err}, {31'd0, ERR_EN & m_err});

        // rejected window (S>E) and unknown command
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd20); send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd10);
        send_byte(1'b0, 8'h55);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        wait_pix("reject_pulse");
        chk("reject_xy", {pix_x[15:0], pix_y[15:0]}, {16'd10, 16'd5});
        chk("reject_err", {31'd0, rx_err}, {31'd0, ERR_EN});

        // resetN clears the flag, then a rd/wr overlap raises it again
        do_reset();
        @(negedge clk_100);
        chk("rst2_rx_err", {31'd0, rx_err}, 32'd0);
        chk("rst2_pix_x", pix_x, 32'd0);
        bus.lcd_rd = 1'b0;
        send_byte(1'b0, 8'h2C);
        bus.lcd_rd = 1'b1;
        m_err = 1'b1;
        repeat (2) @(posedge clk_100); #1;
        chk("overlap_err", {31'd0, rx_err}, {31'd0, ERR_EN});

        // panel reset mid-RAMWR: back to idle with the default window
        do_reset();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd3); send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd7);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h55);
        @(posedge clk_100); #1 bus.lcd_reset = 1'b0;
        repeat (4) @(posedge clk_100);
        #1 bus.lcd_reset = 1'b1;
        repeat (4) @(posedge clk_100);
        model_defaults();
        p0 = n_pulses;
        send_byte(1'b1, 8'hAA); send_byte(1'b1, 8'hBB);
        repeat (8) @(posedge clk_100);
        chk("prst_no_pix", n_pulses - p0, 32'd0);
        chk("prst_err", {31'd0, rx_err}, {31'd0, ERR_EN & m_err});
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
        wait_pix("prst_pulse");
        chk("prst_xy", {pix_x[15:0], pix_y[15:0]}, 32'd0);

        // random command/data mix against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1: send_win(8'h2A, 320);
                2, 3: send_win(8'h2B, 240);
                4, 5, 6: begin
                    send_byte(1'b0, 8'h2C);
                    repeat ($urandom_range(0, 14)) send_byte(1'b1, 8'($urandom_range(0, 255)));
                end
                7: send_byte(1'b0, 8'h01);
                8: send_byte(1'b0, 8'($urandom_range(0, 255)));
                default: repeat ($urandom_range(1, 2)) send_byte(1'b1, 8'($urandom_range(0, 255)));
            endcase
        end
        repeat (10) @(posedge clk_100); #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("final_err", {31'd0, rx_err}, {31'd0, ERR_EN & m_err});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
